uart_tx_scheduler: RTL

//  Sits between the memory-access stage and the uart transmitter.

---
 rtl/uart_tx_scheduler_if.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Bus between the memory-access stage, the transmit scheduler and the uart.
// The master side is the pipeline (push requests), the slave side is the scheduler.
interface uart_tx_scheduler_if #(
  parameter int DEPTH = 16
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic               wr_i;
  logic [7:0]         wr_data_i;
  logic               full_o;
  logic               stall_o;
  logic               overflow_o;
  logic [LEVEL_W-1:0] level_o;
  logic               idle_o;
  logic               uart_wr_o;
  logic [7:0]         uart_dat_o;

  modport master (
    output wr_i, wr_data_i,
    input  full_o, stall_o, overflow_o, level_o, idle_o, uart_wr_o, uart_dat_o
  );

  modport slave (
    input  wr_i, wr_data_i,
    output full_o, stall_o, overflow_o, level_o, idle_o, uart_wr_o, uart_dat_o
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: buffers stores to UART_ADDR in a FIFO and releases
// one byte per frame slot as a single-cycle write strobe to the uart.
module uart_tx_scheduler #(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = 10850
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;
  localparam int TIMER_W = $clog2(FRAME_CYCLES) + 1;

  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] ONE_LEVEL  = LEVEL_W'(1);
  // The timer counts the cycles left in the current slot, the strobe cycle
  // included, so loading FRAME_CYCLES spaces strobes exactly FRAME_CYCLES apart.
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(FRAME_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic               overflow_reg;
  logic               uart_wr_reg;
  logic [7:0]         uart_dat_reg;
  state_t             state_reg;
  state_t             state_next;
  logic [TIMER_W-1:0] timer_reg;
  logic [TIMER_W-1:0] timer_next;

  logic full;
  logic fifo_empty;
  logic push;
  logic pop;

  // Full is judged on the registered level only, so a pop in the same cycle
  // never rescues a push made against a full FIFO.
  assign full       = (level_reg == FULL_LEVEL);
  assign fifo_empty = (level_reg == '0);
  assign push       = bus.wr_i & ~full;

  // Next-state logic: pop at the start of each slot while data is queued.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          timer_next = TIMER_LOAD;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer_reg == TIMER_ONE) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            timer_next = TIMER_LOAD;
          end else begin
            timer_next = '0;
            state_next = ST_IDLE;
          end
        end else begin
          timer_next = timer_reg - TIMER_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // State and slot timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // FIFO storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.wr_data_i;
    end
  end

  // FIFO pointers, occupancy counter, sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + ONE_LEVEL;
        2'b01:   level_reg <= level_reg - ONE_LEVEL;
        default: level_reg <= level_reg;
      endcase
      if (bus.wr_i && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Uart strobe and data: registered read of the FIFO head on each pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_wr_reg  <= 1'b0;
      uart_dat_reg <= 8'h00;
    end else begin
      uart_wr_reg <= pop;
      if (pop) begin
        uart_dat_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign bus.full_o     = full;
  assign bus.stall_o    = bus.wr_i & full;
  assign bus.overflow_o = overflow_reg;
  assign bus.level_o    = level_reg;
  assign bus.idle_o     = (state_reg == ST_IDLE) && fifo_empty;
  assign bus.uart_wr_o  = uart_wr_reg;
  assign bus.uart_dat_o = uart_dat_reg;
endmodule
